hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage core.
- Decides each cycle whether the IF/ID pair advances, stalls, or has a bubble injected into ID/EX.
- Source of stalls:
  - RAW hazards: Tuse/Tnew comparison against the EX and MEM destination registers.
  - The multi-cycle mult/div unit.
- Owns the mult/div busy countdown and drives the enables of PC, IFtoID, IDtoEX and EXtoMEM.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/md_busy_cnt.sv | 40 ++++
 rtl/hazard_ctrl.sv | 85 ++++++++
 tb/tb_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and helpers for the 5-stage core's pipeline control.
package cpu_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned TUSE_W      = 2;
    localparam int unsigned TNEW_W      = 2;
    localparam int unsigned STALL_CNT_W = 32;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;
    localparam int unsigned CNT_W_DEF    = 4;

    // Tuse value meaning the operand is never read
    localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

    // RAW check of one ID source operand against the EX and MEM producers
    function automatic logic raw_hit(
        input logic [REG_W-1:0]  src,
        input logic [TUSE_W-1:0] tuse,
        input logic [REG_W-1:0]  e_addr,
        input logic [TNEW_W-1:0] e_tnew,
        input logic [REG_W-1:0]  m_addr,
        input logic [TNEW_W-1:0] m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = (src == e_addr) && (tuse < e_tnew);
        m_hit = (src == m_addr) && (tuse < m_tnew);
        return (src != '0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div occupancy counter: reloads on an op start, counts down to idle.
module md_busy_cnt
    import cpu_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_i,
    input  logic md_div_i,
    output logic md_busy_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A new op always reloads, even over a running one
    always_comb begin
        cnt_d = cnt_q;
        if (md_start_i) begin
            cnt_d = md_div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register; reset beats a simultaneous start
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: RAW and mult/div stall detection, stage enables, stall counter.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_md_use,
    input  logic [4:0]  E_RegAddr,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_RegAddr,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        PC_en,
    output logic        IFtoID_en,
    output logic        IDtoEX_clr,
    output logic        EXtoMEM_en,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic [STALL_CNT_W-1:0] stall_cycles_d;

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk        (clk),
        .reset      (reset),
        .md_start_i (E_md_start),
        .md_div_i   (E_md_div),
        .md_busy_o  (md_busy)
    );

    // Stall decision; an op entering EX this cycle blocks a dependent md op too
    always_comb begin
        stall_rs = raw_hit(D_rs, D_tuse_rs, E_RegAddr, E_tnew, M_RegAddr, M_tnew);
        stall_rt = raw_hit(D_rt, D_tuse_rt, E_RegAddr, E_tnew, M_RegAddr, M_tnew);
        stall_md = D_md_use && (md_busy || E_md_start);
        stall    = stall_rs || stall_rt || stall_md;
    end

    // Stage controls: freeze front end and inject one bubble on any stall
    always_comb begin
        PC_en      = ~stall;
        IFtoID_en  = ~stall;
        IDtoEX_clr = stall;
        EXtoMEM_en = 1'b1;
    end

    // Saturating stall-cycle count
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed sequences, random vs model.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tur;
        logic [1:0] tut;
        logic       mdu;
        logic [4:0] era;
        logic [1:0] etn;
        logic [4:0] mra;
        logic [1:0] mtn;
        logic       st;
        logic       dv;
        logic       rst;
    } in_t;

    typedef struct packed {
        in_t  v;
        logic exp_stall;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_RegAddr, M_RegAddr;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_md_use, E_md_start, E_md_div;
    logic        PC_en, IFtoID_en, IDtoEX_clr, EXtoMEM_en, md_busy;
    logic [31:0] stall_cycles;

    int          checks = 0;
    int          failures = 0;

    // Reference model state: remaining busy cycles and stall total
    int          m_busy_rem = 0;
    longint      m_stall_cnt = 0;

    // Outputs sampled in the latest step
    logic        s_stall, s_busy;
    logic [31:0] s_cnt;

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .D_rs         (D_rs),
        .D_rt         (D_rt),
        .D_tuse_rs    (D_tuse_rs),
        .D_tuse_rt    (D_tuse_rt),
        .D_md_use     (D_md_use),
        .E_RegAddr    (E_RegAddr),
        .E_tnew       (E_tnew),
        .M_RegAddr    (M_RegAddr),
        .M_tnew       (M_tnew),
        .E_md_start   (E_md_start),
        .E_md_div     (E_md_div),
        .PC_en        (PC_en),
        .IFtoID_en    (IFtoID_en),
        .IDtoEX_clr   (IDtoEX_clr),
        .EXtoMEM_en   (EXtoMEM_en),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input int rs, input int tur, input int rt, input int tut,
                               input int era, input int etn, input int mra, input int mtn,
                               input int mdu);
        in_t v;
        v     = '0;
        v.rs  = 5'(rs);
        v.tur = 2'(tur);
        v.rt  = 5'(rt);
        v.tut = 2'(tut);
        v.era = 5'(era);
        v.etn = 2'(etn);
        v.mra = 5'(mra);
        v.mtn = 2'(mtn);
        v.mdu = 1'(mdu);
        return v;
    endfunction

    function automatic in_t idle();
        return mk(0, 3, 0, 3, 0, 0, 0, 0, 0);
    endfunction

    // Operand needed before its producer delivers it
    function automatic bit operand_waits(input int r, input int tuse, input in_t v);
        if (r == 0 || tuse == 3) return 0;
        if (r == int'(v.era) && tuse < int'(v.etn)) return 1;
        if (r == int'(v.mra) && tuse < int'(v.mtn)) return 1;
        return 0;
    endfunction

    function automatic bit model_stall(input in_t v);
        bit md_wait;
        md_wait = v.mdu && (m_busy_rem > 0 || v.st);
        return operand_waits(int'(v.rs), int'(v.tur), v) ||
               operand_waits(int'(v.rt), int'(v.tut), v) || md_wait;
    endfunction

    // One cycle: drive at negedge, check just after, advance model at posedge
    task automatic step(input in_t v);
        bit exp_stall;
        @(negedge clk);
        D_rs = v.rs; D_rt = v.rt; D_tuse_rs = v.tur; D_tuse_rt = v.tut;
        D_md_use = v.mdu; E_RegAddr = v.era; E_tnew = v.etn;
        M_RegAddr = v.mra; M_tnew = v.mtn; E_md_start = v.st; E_md_div = v.dv;
        reset = v.rst;
        #1;
        exp_stall = model_stall(v);
        chk("pc_en", 32'(PC_en), 32'(!exp_stall));
        chk("ifid_en", 32'(IFtoID_en), 32'(!exp_stall));
        chk("idex_clr", 32'(IDtoEX_clr), 32'(exp_stall));
        chk("exmem_en", 32'(EXtoMEM_en), 32'd1);
        chk("md_busy", 32'(md_busy), 32'(m_busy_rem > 0));
        chk("stall_cycles", stall_cycles, 32'(m_stall_cnt));
        s_stall = IDtoEX_clr;
        s_busy  = md_busy;
        s_cnt   = stall_cycles;
        @(posedge clk);
        if (v.rst) begin
            m_busy_rem  = 0;
            m_stall_cnt = 0;
        end else begin
            if (v.st) m_busy_rem = v.dv ? 10 : 5;
            else if (m_busy_rem > 0) m_busy_rem--;
            if (exp_stall && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
        end
    endtask

    task automatic do_reset();
        in_t v;
        v = idle();
        v.rst = 1'b1;
        step(v);
    endtask

    vec_t tv[12];

    initial begin
        in_t v;

        // Bring-up reset before the first checked cycle
        reset = 1'b1; D_rs = '0; D_rt = '0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        D_md_use = 1'b0; E_RegAddr = '0; E_tnew = '0; M_RegAddr = '0; M_tnew = '0;
        E_md_start = 1'b0; E_md_div = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        step(idle());
        chk("reset_busy", 32'(s_busy), 32'd0);
        chk("reset_cnt", s_cnt, 32'd0);
        chk("reset_stall", 32'(s_stall), 32'd0);

        // Combinational RAW vectors
        tv[0]  = '{mk(8, 0, 0, 3, 8, 2, 0, 0, 0), 1'b1};
        tv[1]  = '{mk(8, 1, 0, 3, 8, 2, 0, 0, 0), 1'b1};
        tv[2]  = '{mk(8, 2, 0, 3, 8, 2, 0, 0, 0), 1'b0};
        tv[3]  = '{mk(0, 0, 0, 3, 0, 2, 0, 0, 0), 1'b0};
        tv[4]  = '{mk(8, 3, 0, 3, 8, 2, 0, 0, 0), 1'b0};
        tv[5]  = '{mk(0, 3, 9, 0, 0, 0, 9, 1, 0), 1'b1};
        tv[6]  = '{mk(0, 3, 9, 1, 0, 0, 9, 1, 0), 1'b0};
        tv[7]  = '{mk(5, 0, 0, 3, 6, 2, 0, 0, 0), 1'b0};
        tv[8]  = '{mk(4, 0, 0, 3, 0, 0, 4, 0, 0), 1'b0};
        tv[9]  = '{mk(7, 0, 7, 0, 7, 2, 0, 0, 0), 1'b1};
        tv[10] = '{mk(0, 3, 0, 3, 0, 0, 0, 0, 1), 1'b0};
        tv[11] = '{mk(0, 3, 0, 0, 0, 0, 0, 1, 0), 1'b0};
        for (int i = 0; i < 12; i++) begin
            step(tv[i].v);
            chk($sformatf("vec%0d_stall", i), 32'(s_stall), 32'(tv[i].exp_stall));
        end

        // lw-use: EX then MEM producer, then clear
        do_reset();
        step(mk(8, 0, 0, 3, 8, 2, 0, 0, 0));
        chk("lwuse_ex", 32'(s_stall), 32'd1);
        step(mk(8, 0, 0, 3, 0, 0, 8, 1, 0));
        chk("lwuse_mem", 32'(s_stall), 32'd1);
        step(mk(8, 0, 0, 3, 0, 0, 0, 0, 0));
        chk("lwuse_free", 32'(s_stall), 32'd0);
        chk("lwuse_count", s_cnt, 32'd2);

        // mult: busy t+1..t+5, md user stalls t..t+5
        for (int i = 0; i <= 6; i++) begin
            v = mk(0, 3, 0, 3, 0, 0, 0, 0, 1);
            v.st = (i == 0);
            step(v);
            chk($sformatf("mult_busy%0d", i), 32'(s_busy), 32'((i >= 1) && (i <= 5)));
            chk($sformatf("mult_stall%0d", i), 32'(s_stall), 32'(i <= 5));
        end

        // div: busy exactly 10 cycles
        for (int i = 0; i <= 11; i++) begin
            v = idle();
            v.st = (i == 0);
            v.dv = 1'b1;
            step(v);
            chk($sformatf("div_busy%0d", i), 32'(s_busy), 32'((i >= 1) && (i <= 10)));
        end

        // div aborted by reset at busy cycle 4
        v = idle(); v.st = 1'b1; v.dv = 1'b1;
        step(v);
        for (int i = 1; i <= 3; i++) step(mk(0, 3, 0, 3, 0, 0, 0, 0, 1));
        v = idle(); v.rst = 1'b1;
        step(v);
        chk("div_abort_pre", 32'(s_busy), 32'd1);
        step(idle());
        chk("div_abort_busy", 32'(s_busy), 32'd0);
        chk("div_abort_cnt", s_cnt, 32'd0);

        // reset with simultaneous start
        v = idle(); v.rst = 1'b1; v.st = 1'b1;
        step(v);
        step(idle());
        chk("rst_start_busy", 32'(s_busy), 32'd0);

        // start while busy at cnt=3 reloads to MULT_CYC
        v = idle(); v.st = 1'b1;
        step(v);
        step(idle());
        step(idle());
        step(v);
        for (int i = 1; i <= 6; i++) begin
            step(idle());
            chk($sformatf("reload_busy%0d", i), 32'(s_busy), 32'(i <= 5));
        end

        // Saturation from FFFF_FFFE with stall held 3 cycles
        @(negedge clk);
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        m_stall_cnt = 64'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(mk(8, 0, 0, 3, 8, 2, 0, 0, 0));
        step(idle());
        chk("sat_hold", s_cnt, 32'hFFFF_FFFF);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v     = '0;
            v.rs  = 5'($urandom_range(0, 3));
            v.rt  = 5'($urandom_range(0, 3));
            v.tur = 2'($urandom_range(0, 3));
            v.tut = 2'($urandom_range(0, 3));
            v.mdu = 1'($urandom_range(0, 3) == 0);
            v.era = 5'($urandom_range(0, 3));
            v.etn = 2'($urandom_range(0, 2));
            v.mra = 5'($urandom_range(0, 3));
            v.mtn = 2'($urandom_range(0, 1));
            v.st  = 1'($urandom_range(0, 7) == 0);
            v.dv  = 1'($urandom_range(0, 1));
            v.rst = 1'($urandom_range(0, 49) == 0);
            step(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
